// File: rtl/aes_decipher_ctrl.sv
// aes_decipher_ctrl: AES inverse-cipher round sequencer (INIT, 4x S-box words, ROUND per key).
// Optional abort input when AES_DECIPHER_CTRL_ABORT_EN is defined.
module aes_decipher_ctrl #(
    parameter int NR128 = 10,
    parameter int NR256 = 14
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       next,
    input  logic       keylen,
`ifdef AES_DECIPHER_CTRL_ABORT_EN
    input  logic       abort,
`endif
    output logic [3:0] round_key_addr,
    output logic [1:0] round_type,
    output logic [1:0] sword_idx,
    output logic       sword_we,
    output logic       block_we,
    output logic       ready
);
    localparam logic [3:0] NR_A = 4'(NR128);
    localparam logic [3:0] NR_B = 4'(NR256);
    localparam logic [1:0] T_INIT = 2'd0;
    localparam logic [1:0] T_MAIN = 2'd1;
    localparam logic [1:0] T_FINAL = 2'd2;

    typedef enum logic [1:0] {IDLE, INIT, SBOX, ROUND} state_t;

    state_t     state;
    logic [3:0] cnt;
    logic       ks;

    // Outputs are registered alongside the state they belong to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt <= 4'd0;
            ks <= 1'b0;
            ready <= 1'b1;
            round_key_addr <= 4'd0;
            round_type <= T_INIT;
            sword_idx <= 2'd0;
            sword_we <= 1'b0;
            block_we <= 1'b0;
        end else begin
            sword_we <= 1'b0;
            block_we <= 1'b0;
            case (state)
                IDLE: if (next) begin
                    ks <= keylen;
                    cnt <= keylen ? NR_B : NR_A;
                    round_key_addr <= keylen ? NR_B : NR_A;
                    round_type <= T_INIT;
                    ready <= 1'b0;
                    block_we <= 1'b1;
                    state <= INIT;
                end
                INIT: begin
                    cnt <= (ks ? NR_B : NR_A) - 4'd1;
                    round_key_addr <= (ks ? NR_B : NR_A) - 4'd1;
                    sword_idx <= 2'd0;
                    sword_we <= 1'b1;
                    state <= SBOX;
                end
                SBOX: if (sword_idx == 2'd3) begin
                    sword_idx <= 2'd0;
                    round_type <= (cnt != 4'd0) ? T_MAIN : T_FINAL;
                    block_we <= 1'b1;
                    state <= ROUND;
                end else begin
                    sword_idx <= sword_idx + 2'd1;
                    sword_we <= 1'b1;
                end
                ROUND: if (cnt != 4'd0) begin
                    cnt <= cnt - 4'd1;
                    round_key_addr <= cnt - 4'd1;
                    sword_we <= 1'b1;
                    state <= SBOX;
                end else begin
                    round_key_addr <= 4'd0;
                    round_type <= T_INIT;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
`ifdef AES_DECIPHER_CTRL_ABORT_EN
            // Abort overrides whatever the case above scheduled.
            if (abort && state != IDLE) begin
                state <= IDLE;
                cnt <= 4'd0;
                ready <= 1'b1;
                round_key_addr <= 4'd0;
                round_type <= T_INIT;
                sword_idx <= 2'd0;
                sword_we <= 1'b0;
                block_we <= 1'b0;
            end
`endif
        end
    end
endmodule
